// File: rtl/coo_sparse_packer.sv
// rtl/coo_sparse_packer.sv - dense vector to COO (address, value) packet encoder
module coo_sparse_packer #(
    parameter int DATA_SIZE  = 8,
    parameter int PACK_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_WIDTH-1:0]                data_in [0:DATA_SIZE-1],
    input  logic                                 data_in_valid,
    output logic                                 data_in_ready,
    output logic [ADDR_WIDTH-1:0]                addr_out [0:PACK_SIZE-1],
    output logic [DATA_WIDTH-1:0]                data_out [0:PACK_SIZE-1],
    output logic [$clog2(PACK_SIZE+1)-1:0]       count_out,
    output logic                                 data_out_valid,
    input  logic                                 data_out_ready,
    output logic                                 data_out_last
);

    localparam int IW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam int CW = $clog2(PACK_SIZE + 1);

    // All-ones is the invalid address, so it must lie outside the index range.
    if (ADDR_WIDTH <= $clog2(DATA_SIZE)) begin : g_addr_width_check
        $error("coo_sparse_packer: ADDR_WIDTH must exceed $clog2(DATA_SIZE)");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] vec_q   [0:DATA_SIZE-1];
    logic [DATA_WIDTH-1:0] vec_d   [0:DATA_SIZE-1];
    logic [ADDR_WIDTH-1:0] addr_q  [0:PACK_SIZE-1];
    logic [ADDR_WIDTH-1:0] addr_d  [0:PACK_SIZE-1];
    logic [DATA_WIDTH-1:0] val_q   [0:PACK_SIZE-1];
    logic [DATA_WIDTH-1:0] val_d   [0:PACK_SIZE-1];
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         slot_q, slot_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] cur_elem;
    logic [CW-1:0]         slot_next;
    logic                  idx_is_last;

    assign data_in_ready  = (state_q == IDLE);
    assign data_out_valid = (state_q == EMIT);
    assign data_out_last  = last_q;
    assign count_out      = count_q;
    assign addr_out       = addr_q;
    assign data_out       = val_q;

    // Next-state logic: latch the vector, scan one element per cycle, hold a packet until accepted.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        addr_d      = addr_q;
        val_d       = val_q;
        idx_d       = idx_q;
        slot_d      = slot_q;
        count_d     = count_q;
        last_d      = last_q;
        cur_elem    = '0;
        slot_next   = slot_q;
        idx_is_last = (idx_q == IW'(DATA_SIZE - 1));

        for (int i = 0; i < DATA_SIZE; i++) begin
            if (idx_q == IW'(i)) begin
                cur_elem = vec_q[i];
            end
        end

        case (state_q)
            IDLE: begin
                if (data_in_valid) begin
                    vec_d   = data_in;
                    idx_d   = '0;
                    slot_d  = '0;
                    count_d = '0;
                    last_d  = 1'b0;
                    for (int s = 0; s < PACK_SIZE; s++) begin
                        addr_d[s] = '1;
                        val_d[s]  = '0;
                    end
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Raw-bit zero test: any set bit (including float -0) is a nonzero.
                if (cur_elem != '0) begin
                    for (int s = 0; s < PACK_SIZE; s++) begin
                        if (slot_q == CW'(s)) begin
                            addr_d[s] = ADDR_WIDTH'(idx_q);
                            val_d[s]  = cur_elem;
                        end
                    end
                    slot_next = slot_q + CW'(1);
                end
                slot_d = slot_next;
                if (slot_next == CW'(PACK_SIZE) || idx_is_last) begin
                    last_d  = idx_is_last;
                    count_d = slot_next;
                    state_d = EMIT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            EMIT: begin
                if (data_out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        for (int s = 0; s < PACK_SIZE; s++) begin
                            addr_d[s] = '1;
                            val_d[s]  = '0;
                        end
                        slot_d  = '0;
                        idx_d   = idx_q + IW'(1);
                        state_d = SCAN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any vector in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            slot_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
            for (int s = 0; s < PACK_SIZE; s++) begin
                addr_q[s] <= '1;
                val_q[s]  <= '0;
            end
            for (int i = 0; i < DATA_SIZE; i++) begin
                vec_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
            count_q <= count_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            val_q   <= val_d;
            vec_q   <= vec_d;
        end
    end

endmodule

// File: tb/tb_coo_sparse_packer.sv
// tb/tb_coo_sparse_packer.sv - directed self-checking bench for coo_sparse_packer
module tb_coo_sparse_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in [0:7];
    logic        data_in_valid;
    logic        data_in_ready;
    logic [15:0] addr_out [0:3];
    logic [15:0] data_out [0:3];
    logic [2:0]  count_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        data_out_last;

    int checks = 0;
    int errors = 0;

    coo_sparse_packer #(
        .DATA_SIZE (8),
        .PACK_SIZE (4),
        .DATA_WIDTH(16),
        .ADDR_WIDTH(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .addr_out      (addr_out),
        .data_out      (data_out),
        .count_out     (count_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .data_out_last (data_out_last)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v [8]);
        for (int i = 0; i < 8; i++) data_in[i] = v[i];
    endtask

    task automatic send(input string tag, input logic [15:0] v [8]);
        load(v);
        data_in_valid = 1'b1;
        chk({tag, "_in_ready"}, {31'd0, data_in_ready}, 32'd1);
        tick();
        data_in_valid = 1'b0;
    endtask

    task automatic wait_pkt(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!data_out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_valid"}, {31'd0, data_out_valid}, 32'd1);
        if (exp_lat >= 0) chk({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic check_pkt(input string tag, input logic [15:0] ea [4], input logic [15:0] ed [4],
                             input int ec, input logic el);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("%s_addr%0d", tag, s), {16'd0, addr_out[s]}, {16'd0, ea[s]});
            chk($sformatf("%s_data%0d", tag, s), {16'd0, data_out[s]}, {16'd0, ed[s]});
        end
        chk({tag, "_count"}, {29'd0, count_out}, ec);
        chk({tag, "_last"}, {31'd0, data_out_last}, {31'd0, el});
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_idle_in_ready"}, {31'd0, data_in_ready}, 32'd1);
        chk({tag, "_idle_valid"}, {31'd0, data_out_valid}, 32'd0);
    endtask

    initial begin
        rst            = 1'b0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) data_in[i] = '0;
        tick();
        tick();

        // reset state
        check_pkt("reset", '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, '{16'd0, 16'd0, 16'd0, 16'd0}, 0, 1'b0);
        check_idle("reset");
        rst = 1'b1;
        tick();

        // reset during SCAN: handshake edge, two scan edges, reset on the third
        send("rs", '{16'd0, 16'd5, 16'd0, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0});
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_idle("rs");
        check_pkt("rs", '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, '{16'd0, 16'd0, 16'd0, 16'd0}, 0, 1'b0);
        send("rs2", '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0});
        wait_pkt("rs2", 8);
        check_pkt("rs2", '{16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF}, '{16'd1, 16'd0, 16'd0, 16'd0}, 1, 1'b1);
        tick();
        check_idle("rs2");

        // basic pack: last element at index 7, valid 8 edges after the handshake edge
        send("basic", '{16'd0, 16'd5, 16'd0, 16'd7, 16'd0, 16'd0, 16'd0, 16'd9});
        wait_pkt("basic", 8);
        check_pkt("basic", '{16'd1, 16'd3, 16'd7, 16'hFFFF}, '{16'd5, 16'd7, 16'd9, 16'd0}, 3, 1'b1);
        tick();
        check_idle("basic");

        // overflow split
        send("ovf", '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0, 16'd0});
        wait_pkt("ovf1", 4);
        check_pkt("ovf1", '{16'd0, 16'd1, 16'd2, 16'd3}, '{16'd1, 16'd2, 16'd3, 16'd4}, 4, 1'b0);
        tick();
        wait_pkt("ovf2", 4);
        check_pkt("ovf2", '{16'd4, 16'd5, 16'hFFFF, 16'hFFFF}, '{16'd5, 16'd6, 16'd0, 16'd0}, 2, 1'b1);
        tick();
        check_idle("ovf2");

        // exact fill on the final index: no trailing empty packet
        send("exact", '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4});
        wait_pkt("exact", 8);
        check_pkt("exact", '{16'd4, 16'd5, 16'd6, 16'd7}, '{16'd1, 16'd2, 16'd3, 16'd4}, 4, 1'b1);
        tick();
        check_idle("exact");
        tick();
        tick();
        check_idle("exact_after");

        // early fill then zeros: padding-only packet follows
        send("trail", '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0});
        wait_pkt("trail1", 4);
        check_pkt("trail1", '{16'd0, 16'd1, 16'd2, 16'd3}, '{16'd1, 16'd2, 16'd3, 16'd4}, 4, 1'b0);
        tick();
        wait_pkt("trail2", 4);
        check_pkt("trail2", '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, '{16'd0, 16'd0, 16'd0, 16'd0}, 0, 1'b1);
        tick();
        check_idle("trail2");

        // all-zero vector
        send("zero", '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0});
        wait_pkt("zero", 8);
        check_pkt("zero", '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, '{16'd0, 16'd0, 16'd0, 16'd0}, 0, 1'b1);
        tick();
        check_idle("zero");

        // back-pressure on packet 1 of the overflow case, with a competing input offered
        data_out_ready = 1'b0;
        send("bp", '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0, 16'd0});
        wait_pkt("bp1", 4);
        check_pkt("bp1", '{16'd0, 16'd1, 16'd2, 16'd3}, '{16'd1, 16'd2, 16'd3, 16'd4}, 4, 1'b0);
        load('{16'hAAAA, 16'hBBBB, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'h1111});
        data_in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp_hold%0d_valid", c), {31'd0, data_out_valid}, 32'd1);
            chk($sformatf("bp_hold%0d_in_ready", c), {31'd0, data_in_ready}, 32'd0);
            chk($sformatf("bp_hold%0d_addr3", c), {16'd0, addr_out[3]}, 32'd3);
            chk($sformatf("bp_hold%0d_data0", c), {16'd0, data_out[0]}, 32'd1);
            chk($sformatf("bp_hold%0d_count", c), {29'd0, count_out}, 32'd4);
            chk($sformatf("bp_hold%0d_last", c), {31'd0, data_out_last}, 32'd0);
        end
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        tick();
        wait_pkt("bp2", 4);
        check_pkt("bp2", '{16'd4, 16'd5, 16'hFFFF, 16'hFFFF}, '{16'd5, 16'd6, 16'd0, 16'd0}, 2, 1'b1);
        tick();
        check_idle("bp2");
        tick();
        tick();
        check_idle("bp_no_accept");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coo_sparse_packer.md
Name: coo_sparse_packer

Overview:
- Encoder side of the COO sparse path: accepts one dense vector of DATA_SIZE elements and emits one or more COO packets.
- Each packet holds PACK_SIZE (address, value) slots for the nonzero elements, in ascending index order.
- Unused slots carry the "invalid" address (all ones, negative when signed) and value 0. The downstream gather fetcher returns 0 for any negative address.
- Sits between dense activation/weight producers and sparse compute or storage.

Parameters:
- DATA_SIZE, 8: elements per dense input vector.
- PACK_SIZE, 4: slots per output packet.
- DATA_WIDTH, 16: element width.
- ADDR_WIDTH, 16: address width. Must satisfy ADDR_WIDTH > $clog2(DATA_SIZE) so that all-ones never aliases a real index; elaboration error otherwise.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low (asserted when 0).
- data_in  in  DATA_WIDTH x [0:DATA_SIZE-1]  dense vector.
- data_in_valid  in  1  data_in valid.
- data_in_ready  out  1  block can accept a vector.
- addr_out  out  ADDR_WIDTH x [0:PACK_SIZE-1]  COO address table.
- data_out  out  DATA_WIDTH x [0:PACK_SIZE-1]  COO values.
- count_out  out  $clog2(PACK_SIZE+1)  number of valid slots in the packet.
- data_out_valid  out  1  packet valid.
- data_out_ready  in  1  downstream accepts the packet.
- data_out_last  out  1  final packet of the current vector.

Behaviour:
- Reset (rst==0 at an edge) applies from any state, including mid-scan or mid-emit:
  - state=IDLE, data_in_ready=1, data_out_valid=0, data_out_last=0, count_out=0.
  - all addr_out = all ones; all data_out = 0; idx=0, slot=0.
  - Any vector in flight is discarded.
- IDLE:
  - data_in_ready=1.
  - On data_in_valid & data_in_ready, latch data_in into an internal buffer, set idx=0, slot=0, and go to SCAN.
  - data_in_ready=0 from the next cycle until return to IDLE.
- SCAN: one element per cycle, element buf[idx].
  - If buf[idx] != 0: addr_out[slot] <= idx (zero-extended), data_out[slot] <= buf[idx], slot++.
  - Then, if slot became PACK_SIZE or idx==DATA_SIZE-1, go to EMIT next cycle. data_out_last <= (idx==DATA_SIZE-1), count_out <= the new slot count.
  - Otherwise idx++ and stay in SCAN.
- EMIT:
  - data_out_valid=1. addr_out, data_out, count_out and data_out_last are held stable until data_out_ready.
  - On handshake with last=1: go to IDLE, data_out_valid=0 next cycle.
  - On handshake with last=0: clear all slots to all-ones/0, slot=0, idx++, return to SCAN.
- Latency, no back-pressure: input handshake at cycle T, the last element of the packet is scanned at cycle T+k (k = that element's index+1), and data_out_valid rises at T+k+1.
  - Full vector with no overflow: valid at T+DATA_SIZE+1.
- Boundary cases:
  - All-zero vector: one packet, count=0, all slots invalid, last=1.
  - Slot fills exactly on index DATA_SIZE-1: that packet has last=1; no trailing empty packet.
  - Slot fills before index DATA_SIZE-1 and all remaining elements are zero: a padding-only packet follows with count=0, last=1.
- Zero test: nonzero means any bit set. Values are treated as raw bits, so -0 in float formats counts as nonzero.
- Ordering: valid slots are filled contiguously from slot 0, with addresses strictly increasing within and across packets.
- No new input is accepted while a vector is being packed. data_in_ready is registered and does not depend combinationally on data_out_ready.

Test Plan:
- Reset mid-SCAN:
  - Stimulus: input {0,5,0,7,0,0,0,0}; drive rst=0 at T+3 for one cycle.
  - Required: next cycle data_in_ready=1, data_out_valid=0, all addr_out=16'hFFFF; a following vector {1,0,...} packs correctly.
- Basic pack:
  - Stimulus: input {0,5,0,7,0,0,0,9}, data_out_ready=1.
  - Required: valid at T+9; addr={1,3,7,FFFF}, data={5,7,9,0}, count=3, last=1; data_in_ready=1 the cycle after the handshake.
- Overflow split:
  - Stimulus: input {1,2,3,4,5,6,0,0}.
  - Required: packet1 addr={0,1,2,3}, data={1,2,3,4}, count=4, last=0, valid at T+5.
  - Required: packet2 addr={4,5,FFFF,FFFF}, data={5,6,0,0}, count=2, last=1.
- Exact fill:
  - Stimulus: input {0,0,0,0,1,2,3,4}.
  - Required: single packet addr={4,5,6,7}, count=4, last=1; no empty packet.
- Trailing empty packet and all-zero input:
  - Stimulus: input {1,2,3,4,0,0,0,0}.
  - Required: packet1 count=4, last=0; packet2 count=0, last=1, all addr FFFF.
  - Stimulus: all-zero input.
  - Required: one packet, count=0, last=1.
- Back-pressure:
  - Stimulus: hold data_out_ready=0 for 5 cycles during packet1 of the overflow case.
  - Required: outputs stable and valid held; packet2 is not started until the handshake; data_in_valid presented meanwhile is not accepted.
